spwm_carrier_ctrl: RTL and testbench

Sequencer for the SPWM triangle carrier. It replaces the free-running carrier counter with a controlled up/down counter that has a programmable peak and a clock prescaler. New configuration is accepted through a valid/ready handshake and applied only at a carrier valley, so no PWM period is ever glitched. Sits between the control register interface and the SPWM comparators, and provides peak/valley sync pulses for sampling the modulating reference.

---
 rtl/spwm_pkg.sv | 25 ++
 rtl/spwm_prescaler.sv | 45 ++++
 rtl/spwm_carrier_ctrl.sv | 174 +++++++++++++++++
 tb/tb_spwm_carrier_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spwm_pkg.sv
// ---------------------------------------------------------------------------
// spwm_pkg
// Shared definitions for the SPWM triangle carrier sequencer.
//   - default carrier and prescaler widths
//   - carrier sequencer state enum
//   - direction and pulse encodings used on the dir/peak/valley outputs
// ---------------------------------------------------------------------------
package spwm_pkg;

  localparam int DEF_WIDTH   = 10;
  localparam int DEF_PRESC_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } spwm_state_e;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

  localparam logic PULSE_ON  = 1'b1;
  localparam logic PULSE_OFF = 1'b0;

endpackage

// File: rtl/spwm_prescaler.sv
// ---------------------------------------------------------------------------
// spwm_prescaler
// Divides the system clock down to carrier steps. The count runs
// 0..presc_i and a tick is flagged on the clock where the count has reached
// presc_i; the count then wraps to 0. While clear_i is high the count is held
// at zero and no tick is produced, so a fresh start always waits a full
// presc_i+1 clocks for its first step.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset
//   clear_i  hold the count at zero (carrier idle)
//   presc_i  clocks per carrier step minus one
//   tick_o   carrier step strobe for this clock
// ---------------------------------------------------------------------------
module spwm_prescaler
  import spwm_pkg::*;
#(
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clear_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               tick_o
);

  logic [PRESC_W-1:0] count_q;

  // The >= comparison keeps the divider from running away through the full
  // counter range if the division ratio were ever lowered below the count.
  assign tick_o = ~clear_i & (count_q >= presc_i);

  // Free-running divider count, parked at zero while the carrier is idle.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      count_q <= '0;
    end else if (count_q >= presc_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + PRESC_W'(1);
    end
  end

endmodule

// File: rtl/spwm_carrier_ctrl.sv
// ---------------------------------------------------------------------------
// spwm_carrier_ctrl
// Triangle carrier sequencer for the SPWM comparators. Generates an up/down
// carrier 0..period..0 stepped by a prescaler, with one-clock peak/valley
// sync pulses. New period/prescaler values arrive over a valid/ready
// handshake into a shadow register and are only copied to the active set at
// a carrier valley (or immediately while idle), so a PWM period is never
// cut short or stretched mid-ramp.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           synchronous active-high reset
//   en_i            run request (level)
//   cfg_valid_i     new configuration offered
//   cfg_ready_o     shadow slot free
//   cfg_period_i    requested peak value (0 is treated as 1)
//   cfg_presc_i     clocks per carrier step minus one
//   carrier_o       unsigned triangle carrier
//   dir_o           1 = counting up, 0 = counting down
//   peak_pulse_o    one clock, coincident with carrier reaching the peak
//   valley_pulse_o  one clock, coincident with carrier returning to 0
//   running_o       carrier active (RUN or STOP)
// ---------------------------------------------------------------------------
module spwm_carrier_ctrl
  import spwm_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESC_W    = DEF_PRESC_W,
  parameter int RST_PERIOD = 1023,
  parameter int RST_PRESC  = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [WIDTH-1:0]   cfg_period_i,
  input  logic [PRESC_W-1:0] cfg_presc_i,
  output logic [WIDTH-1:0]   carrier_o,
  output logic               dir_o,
  output logic               peak_pulse_o,
  output logic               valley_pulse_o,
  output logic               running_o
);

  spwm_state_e        state_q;
  logic [WIDTH-1:0]   carrier_q;
  logic               dir_q;
  logic               peakPulse_q;
  logic               valleyPulse_q;
  logic               running_q;
  logic [WIDTH-1:0]   activePeriod_q;
  logic [PRESC_W-1:0] activePresc_q;
  logic [WIDTH-1:0]   pendPeriod_q;
  logic [PRESC_W-1:0] pendPresc_q;
  logic               pendValid_q;

  logic               accept;
  logic               tick;
  logic               prescClear;
  logic [WIDTH-1:0]   cfgPeriodClamped;
  logic [WIDTH-1:0]   carrierUp;
  logic [WIDTH-1:0]   carrierDown;

  // The shadow slot is free whenever nothing is waiting to be applied; a
  // zero period would stall the ramp, so it is stored as 1.
  assign cfg_ready_o      = ~pendValid_q;
  assign accept           = cfg_valid_i & ~pendValid_q;
  assign cfgPeriodClamped = (cfg_period_i == '0) ? WIDTH'(1) : cfg_period_i;
  assign carrierUp        = carrier_q + WIDTH'(1);
  assign carrierDown      = carrier_q - WIDTH'(1);
  assign prescClear       = (state_q == IDLE);

  assign carrier_o      = carrier_q;
  assign dir_o          = dir_q;
  assign peak_pulse_o   = peakPulse_q;
  assign valley_pulse_o = valleyPulse_q;
  assign running_o      = running_q;

  spwm_prescaler #(
    .PRESC_W (PRESC_W)
  ) uPrescaler (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (prescClear),
    .presc_i (activePresc_q),
    .tick_o  (tick)
  );

  // Sequencer FSM, up/down counter and shadow configuration in one block.
  // IDLE holds the carrier at zero and applies any pending configuration on
  // the next clock; a configuration accepted in the same clock as en keeps
  // the sequencer in IDLE one extra clock so the first step already uses it.
  // RUN/STOP both count; STOP leaves for IDLE on the clock after the valley
  // pulse unless en has come back, so a re-enable before then is seamless.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      carrier_q      <= '0;
      dir_q          <= DIR_UP;
      peakPulse_q    <= PULSE_OFF;
      valleyPulse_q  <= PULSE_OFF;
      running_q      <= 1'b0;
      activePeriod_q <= WIDTH'(RST_PERIOD);
      activePresc_q  <= PRESC_W'(RST_PRESC);
      pendPeriod_q   <= '0;
      pendPresc_q    <= '0;
      pendValid_q    <= 1'b0;
    end else begin
      peakPulse_q   <= PULSE_OFF;
      valleyPulse_q <= PULSE_OFF;

      if (accept) begin
        pendPeriod_q <= cfgPeriodClamped;
        pendPresc_q  <= cfg_presc_i;
        pendValid_q  <= 1'b1;
      end

      unique case (state_q)
        IDLE: begin
          carrier_q <= '0;
          dir_q     <= DIR_UP;
          if (pendValid_q) begin
            activePeriod_q <= pendPeriod_q;
            activePresc_q  <= pendPresc_q;
            pendValid_q    <= 1'b0;
          end
          if (en_i && !accept) begin
            state_q   <= RUN;
            running_q <= 1'b1;
          end
        end

        RUN, STOP: begin
          if ((state_q == STOP) && !en_i && (valleyPulse_q == PULSE_ON)) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            carrier_q <= '0;
            dir_q     <= DIR_UP;
          end else begin
            state_q   <= en_i ? RUN : STOP;
            running_q <= 1'b1;
            if (tick) begin
              if (dir_q == DIR_UP) begin
                carrier_q <= carrierUp;
                if (carrierUp == activePeriod_q) begin
                  dir_q       <= DIR_DOWN;
                  peakPulse_q <= PULSE_ON;
                end
              end else begin
                carrier_q <= carrierDown;
                if (carrierDown == '0) begin
                  dir_q         <= DIR_UP;
                  valleyPulse_q <= PULSE_ON;
                  if (pendValid_q) begin
                    activePeriod_q <= pendPeriod_q;
                    activePresc_q  <= pendPresc_q;
                    pendValid_q    <= 1'b0;
                  end
                end
              end
            end
          end
        end

        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spwm_carrier_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spwm_carrier_ctrl
// Bench for the SPWM carrier sequencer. A phase-based model describes the
// carrier as a position within one triangle period (0..2P-1) and derives
// carrier/dir/pulses from it; a negedge process compares every output on
// every clock. Directed scenarios pin the model with hand-computed values,
// followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_spwm_carrier_ctrl;

  localparam int WIDTH   = 10;
  localparam int PRESC_W = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               cfgValid;
  logic [WIDTH-1:0]   cfgPeriod;
  logic [PRESC_W-1:0] cfgPresc;
  logic               cfgReady;
  logic [WIDTH-1:0]   carrier;
  logic               dir;
  logic               peakPulse;
  logic               valleyPulse;
  logic               running;

  int checks   = 0;
  int failures = 0;

  spwm_carrier_ctrl #(
    .WIDTH      (WIDTH),
    .PRESC_W    (PRESC_W),
    .RST_PERIOD (1023),
    .RST_PRESC  (0)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .en_i           (en),
    .cfg_valid_i    (cfgValid),
    .cfg_ready_o    (cfgReady),
    .cfg_period_i   (cfgPeriod),
    .cfg_presc_i    (cfgPresc),
    .carrier_o      (carrier),
    .dir_o          (dir),
    .peak_pulse_o   (peakPulse),
    .valley_pulse_o (valleyPulse),
    .running_o      (running)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Single comparison helper shared by the model checker and directed checks
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic v,
                               input int per, input int pre);
    rst       = r;
    en        = e;
    cfgValid  = v;
    cfgPeriod = WIDTH'(per);
    cfgPresc  = PRESC_W'(pre);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until the requested pulse appears; reports clocks taken
  task automatic waitPulse(input bit wantPeak, input int limit, output int cycles);
    bit found;
    found  = 0;
    cycles = 0;
    while (!found && cycles < limit) begin
      step();
      cycles++;
      if (wantPeak ? peakPulse : valleyPulse) found = 1;
    end
    if (!found) checkOutput(wantPeak ? "peak timeout" : "valley timeout", 0, 1);
  endtask

  // Step until the carrier shows a given value and direction
  task automatic waitCarrier(input int value, input bit wantDir, input int limit);
    int n;
    n = 0;
    while (!(int'(carrier) == value && dir == wantDir) && n < limit) begin
      step();
      n++;
    end
    if (!(int'(carrier) == value && dir == wantDir)) checkOutput("carrier wait timeout", 0, 1);
  endtask

  // ---------------------------------------------------------------------
  // Behavioural model: the carrier is a phase 0..2P-1 within the triangle,
  // advanced once every presc+1 clocks; value = phase folded about P.
  // mState: 0 idle, 1 running with en, 2 running after en dropped.
  // ---------------------------------------------------------------------
  int mState, mPh, mPeriod, mPresc, mDiv, mPendPeriod, mPendPresc;
  bit mPendValid, mPeak, mValley, mAccept, mWasValley, modelReady = 0;

  task automatic modelApply();
    mPeriod    = mPendPeriod;
    mPresc     = mPendPresc;
    mPendValid = 0;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mState = 0; mPh = 0; mPeriod = 1023; mPresc = 0; mDiv = 0;
      mPendValid = 0; mPeak = 0; mValley = 0;
    end else begin
      mAccept    = cfgValid && !mPendValid;
      mWasValley = mValley;
      mPeak      = 0;
      mValley    = 0;
      if (mState == 0) begin
        mPh  = 0;
        mDiv = 0;
        if (mPendValid) modelApply();
        if (en && !mAccept) mState = 1;
      end else if (mState == 2 && !en && mWasValley) begin
        mState = 0;
        mPh    = 0;
      end else begin
        mState = en ? 1 : 2;
        if (mDiv == mPresc) begin
          mDiv = 0;
          mPh  = (mPh + 1) % (2 * mPeriod);
          if (mPh == mPeriod) mPeak = 1;
          if (mPh == 0) begin
            mValley = 1;
            if (mPendValid) modelApply();
          end
        end else begin
          mDiv++;
        end
      end
      if (mAccept) begin
        mPendPeriod = (cfgPeriod == 0) ? 1 : int'(cfgPeriod);
        mPendPresc  = int'(cfgPresc);
        mPendValid  = 1;
      end
    end
    modelReady = 1;
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("carrier",   int'(carrier),     (mPh <= mPeriod) ? mPh : 2 * mPeriod - mPh);
      checkOutput("dir",       int'(dir),         (mPh < mPeriod) ? 1 : 0);
      checkOutput("peak",      int'(peakPulse),   int'(mPeak));
      checkOutput("valley",    int'(valleyPulse), int'(mValley));
      checkOutput("running",   int'(running),     (mState != 0) ? 1 : 0);
      checkOutput("cfg_ready", int'(cfgReady),    mPendValid ? 0 : 1);
    end
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    int cyc;
    applyStimulus(1, 0, 0, 0, 0);
    step();

    // Reset state
    checkOutput("reset carrier", int'(carrier), 0);
    checkOutput("reset dir", int'(dir), 1);
    checkOutput("reset ready", int'(cfgReady), 1);
    checkOutput("reset running", int'(running), 0);

    // Default period 1023, presc 0: peak after 1023 clocks, valley after 2046
    applyStimulus(0, 1, 0, 0, 0);
    step();
    checkOutput("start running", int'(running), 1);
    checkOutput("start carrier", int'(carrier), 0);
    waitPulse(1, 1100, cyc);
    checkOutput("default peak clocks", cyc, 1023);
    checkOutput("default peak value", int'(carrier), 1023);
    en = 0;
    waitPulse(0, 1100, cyc);
    checkOutput("default valley clocks", cyc + 1023, 2046);
    step();
    checkOutput("stopped after valley", int'(running), 0);

    // period 4, presc 2 offered while idle, then enable
    applyStimulus(0, 0, 1, 4, 2);
    step();
    cfgValid = 0;
    checkOutput("idle accept ready", int'(cfgReady), 0);
    step();
    checkOutput("idle apply ready", int'(cfgReady), 1);
    en = 1;
    step();
    waitPulse(1, 40, cyc);
    checkOutput("p4 peak clocks", cyc, 12);
    checkOutput("p4 peak value", int'(carrier), 4);
    waitPulse(0, 40, cyc);
    checkOutput("p4 valley clocks", cyc, 12);

    // period 8 offered mid up-ramp: current ramp still peaks at 4
    waitCarrier(2, 1, 40);
    applyStimulus(0, 1, 1, 8, 2);
    step();
    cfgValid = 0;
    checkOutput("mid-ramp ready low", int'(cfgReady), 0);
    waitPulse(1, 40, cyc);
    checkOutput("old peak kept", int'(carrier), 4);
    waitPulse(0, 40, cyc);
    checkOutput("ready at valley", int'(cfgReady), 1);
    waitPulse(1, 60, cyc);
    checkOutput("new peak", int'(carrier), 8);
    checkOutput("new peak clocks", cyc, 24);

    // Stop request on the up-ramp finishes the period then idles
    waitPulse(0, 60, cyc);
    waitCarrier(3, 1, 60);
    en = 0;
    waitPulse(0, 100, cyc);
    checkOutput("stop valley running", int'(running), 1);
    step();
    checkOutput("stop idle running", int'(running), 0);
    checkOutput("stop idle carrier", int'(carrier), 0);

    // Re-enable on the down-ramp before the valley: no stop
    en = 1;
    step();
    waitCarrier(3, 1, 60);
    en = 0;
    waitCarrier(2, 0, 60);
    en = 1;
    waitPulse(0, 60, cyc);
    step();
    checkOutput("reenable running", int'(running), 1);

    // Period 0 behaves as 1: carrier toggles every clock with presc 0
    en = 0;
    waitPulse(0, 100, cyc);
    step();
    applyStimulus(0, 0, 1, 0, 0);
    step();
    cfgValid = 0;
    step();
    en = 1;
    step();
    step();
    checkOutput("p1 carrier hi", int'(carrier), 1);
    checkOutput("p1 peak", int'(peakPulse), 1);
    step();
    checkOutput("p1 carrier lo", int'(carrier), 0);
    checkOutput("p1 valley", int'(valleyPulse), 1);
    step();
    checkOutput("p1 carrier hi again", int'(carrier), 1);

    // Reset mid-ramp with a pending config: defaults return, pending lost
    rst = 1;
    step();
    rst = 0;
    waitCarrier(500, 1, 1200);
    applyStimulus(0, 1, 1, 5, 1);
    step();
    cfgValid = 0;
    checkOutput("pending ready low", int'(cfgReady), 0);
    rst = 1;
    step();
    rst = 0;
    checkOutput("rst carrier", int'(carrier), 0);
    checkOutput("rst dir", int'(dir), 1);
    checkOutput("rst ready", int'(cfgReady), 1);
    step();
    waitPulse(1, 1100, cyc);
    checkOutput("rst default peak clocks", cyc, 1023);
    checkOutput("rst default peak value", int'(carrier), 1023);

    // Randomized traffic with short periods so many valleys occur
    applyStimulus(1, 0, 0, 0, 0);
    step();
    rst = 0;
    for (int i = 0; i < 5000; i++) begin
      applyStimulus($urandom_range(0, 399) == 0,
                    ($urandom_range(0, 39) == 0) ? ~en : en,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 9),
                    $urandom_range(0, 3));
      step();
    end
    applyStimulus(0, 0, 0, 0, 0);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
